// File: rtl/serial_lane_write_buffer.sv
// Shifts a parallel word onto LANES output lines, one beat per write_sig strobe.
// A one-word pending slot lets back-to-back words stream without an idle gap.
module serial_lane_write_buffer #(
    parameter int   BUF_SIZE   = 8,
    parameter int   LANES      = 1,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1,
    localparam int  BEATS      = BUF_SIZE / LANES,
    localparam int  CNT_W      = $clog2(BEATS + 1)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BUF_SIZE-1:0] data_in,
    input  logic [CNT_W-1:0]    write_count,
    input  logic                write_sig,
    input  logic                abort,
    output logic [LANES-1:0]    data_out,
    output logic                ready,
    output logic                busy,
    output logic                done_sig,
    output logic                word_done
);

    localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
    localparam logic [LANES-1:0] IDLE_BEAT = {LANES{IDLE_LEVEL}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [BUF_SIZE-1:0] shift_reg;
    logic [CNT_W-1:0]    remaining;
    logic                pending_valid;
    logic [BUF_SIZE-1:0] pending_data;
    logic [CNT_W-1:0]    pending_count;
    logic                extra_done;

    logic                accept;
    logic                last_beat;
    logic                nxt_valid;
    logic [BUF_SIZE-1:0] nxt_data;
    logic [CNT_W-1:0]    nxt_count;

    function automatic logic [LANES-1:0] first_beat(input logic [BUF_SIZE-1:0] word);
        return MSB_FIRST ? word[BUF_SIZE-1 -: LANES] : word[LANES-1:0];
    endfunction

    function automatic logic [BUF_SIZE-1:0] shift_out(input logic [BUF_SIZE-1:0] word);
        return MSB_FIRST ? (word << LANES) : (word >> LANES);
    endfunction

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] count);
        return (count > BEATS_C) ? BEATS_C : count;
    endfunction

    assign accept    = start && !pending_valid;
    assign last_beat = write_sig && (remaining == CNT_W'(1));
    assign ready     = !pending_valid;
    assign done_sig  = (state == IDLE) && !pending_valid;

    // The word that follows the active one: the pending slot wins over a fresh start.
    always_comb begin
        nxt_valid = pending_valid || accept;
        nxt_data  = pending_valid ? pending_data : data_in;
        nxt_count = pending_valid ? pending_count : clamp(write_count);
    end

    // NOTE: all state is updated with non-blocking assignments so every branch below
    // reads the pre-edge values, regardless of statement order.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            shift_reg     <= '0;
            remaining     <= '0;
            pending_valid <= 1'b0;
            pending_data  <= '0;
            pending_count <= '0;
            extra_done    <= 1'b0;
            data_out      <= IDLE_BEAT;
            busy          <= 1'b0;
            word_done     <= 1'b0;
        end else begin
            word_done  <= extra_done;
            extra_done <= 1'b0;
            if (abort) begin
                state         <= IDLE;
                remaining     <= '0;
                pending_valid <= 1'b0;
                data_out      <= IDLE_BEAT;
                busy          <= 1'b0;
                word_done     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (nxt_valid) begin
                            if (nxt_count != '0) begin
                                state     <= SHIFT;
                                busy      <= 1'b1;
                                data_out  <= first_beat(nxt_data);
                                shift_reg <= shift_out(nxt_data);
                                remaining <= nxt_count;
                            end else begin
                                word_done <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (last_beat) begin
                            word_done     <= 1'b1;
                            pending_valid <= 1'b0;
                            if (nxt_valid && nxt_count != '0) begin
                                data_out  <= first_beat(nxt_data);
                                shift_reg <= shift_out(nxt_data);
                                remaining <= nxt_count;
                            end else begin
                                // A zero-length follow-on word still owes its own pulse.
                                extra_done <= nxt_valid;
                                state      <= IDLE;
                                busy       <= 1'b0;
                                data_out   <= IDLE_BEAT;
                                remaining  <= '0;
                            end
                        end else begin
                            if (write_sig) begin
                                data_out  <= first_beat(shift_reg);
                                shift_reg <= shift_out(shift_reg);
                                remaining <= remaining - CNT_W'(1);
                            end
                            if (accept) begin
                                pending_valid <= 1'b1;
                                pending_data  <= data_in;
                                pending_count <= clamp(write_count);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_lane_write_buffer.sv
// Bench for serial_lane_write_buffer: a 1-lane MSB-first and a 2-lane LSB-first instance
// share stimulus; outputs are compared to hand tables and to a word-level reference model.
module tb_serial_lane_write_buffer;

    logic       sys_clk;
    logic       rst;
    logic       st;
    logic [7:0] din;
    logic [3:0] wc;
    logic       ws;
    logic       ab;

    logic [0:0] do_a;
    logic       rdy_a, busy_a, done_a, wd_a;
    logic [1:0] do_b;
    logic       rdy_b, busy_b, done_b, wd_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = 1-lane MSB-first, index 1 = 2-lane LSB-first.
    int m_act_data[2];
    int m_act_cnt[2];
    int m_act_idx[2];
    int m_pend_v[2];
    int m_pend_data[2];
    int m_pend_cnt[2];
    int m_wd[2];
    int m_extra[2];

    typedef struct {
        logic       st;
        logic [7:0] d;
        logic [3:0] wc;
        logic       ws;
        logic       ab;
        logic       e_out;
        logic       e_busy;
        logic       e_ready;
        logic       e_done;
        logic       e_wd;
    } vec_t;

    vec_t vecs[21];

    serial_lane_write_buffer #(
        .BUF_SIZE(8), .LANES(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
    ) dut_a (
        .sys_clk(sys_clk), .rst(rst), .start(st), .data_in(din), .write_count(wc),
        .write_sig(ws), .abort(ab), .data_out(do_a), .ready(rdy_a), .busy(busy_a),
        .done_sig(done_a), .word_done(wd_a)
    );

    serial_lane_write_buffer #(
        .BUF_SIZE(8), .LANES(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
    ) dut_b (
        .sys_clk(sys_clk), .rst(rst), .start(st), .data_in(din), .write_count(wc[2:0]),
        .write_sig(ws), .abort(ab), .data_out(do_b), .ready(rdy_b), .busy(busy_b),
        .done_sig(done_b), .word_done(wd_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int beat_of(input int inst, input int data, input int k);
        int lanes;
        int mask;
        lanes = inst + 1;
        mask  = (1 << lanes) - 1;
        if (inst == 0) return (data >> (8 - (k + 1) * lanes)) & mask;
        return (data >> (k * lanes)) & mask;
    endfunction

    function automatic int clamp_cnt(input int inst, input int count);
        int c;
        int beats;
        c     = (inst == 1) ? (count & 7) : count;
        beats = (inst == 1) ? 4 : 8;
        return (c > beats) ? beats : c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act_data[i] = 0; m_act_cnt[i] = 0; m_act_idx[i] = 0;
            m_pend_v[i] = 0; m_pend_data[i] = 0; m_pend_cnt[i] = 0;
            m_wd[i] = 0; m_extra[i] = 0;
        end
    endtask

    task automatic start_word(input int i, input int data, input int cnt);
        m_act_data[i] = data;
        m_act_cnt[i]  = cnt;
        m_act_idx[i]  = 0;
    endtask

    // One clock edge of the model, applied to the inputs held across that edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int wd_n;
            int acc;
            int active;
            int c;
            wd_n = m_extra[i];
            m_extra[i] = 0;
            c = clamp_cnt(i, int'(wc));
            acc = (st && m_pend_v[i] == 0) ? 1 : 0;
            active = (m_act_idx[i] < m_act_cnt[i]) ? 1 : 0;
            if (ab) begin
                m_act_cnt[i] = 0; m_act_idx[i] = 0; m_pend_v[i] = 0; wd_n = 0;
            end else if (active == 0) begin
                if (acc == 1) begin
                    if (c > 0) start_word(i, int'(din), c);
                    else wd_n = 1;
                end
            end else if (ws && m_act_idx[i] == m_act_cnt[i] - 1) begin
                wd_n = 1;
                m_act_cnt[i] = 0; m_act_idx[i] = 0;
                if (m_pend_v[i] == 1) begin
                    m_pend_v[i] = 0;
                    if (m_pend_cnt[i] > 0) start_word(i, m_pend_data[i], m_pend_cnt[i]);
                    else m_extra[i] = 1;
                end else if (acc == 1) begin
                    if (c > 0) start_word(i, int'(din), c);
                    else m_extra[i] = 1;
                end
            end else begin
                if (ws) m_act_idx[i]++;
                if (acc == 1) begin
                    m_pend_v[i] = 1; m_pend_data[i] = int'(din); m_pend_cnt[i] = c;
                end
            end
            m_wd[i] = wd_n;
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            int active;
            int e_out;
            active = (m_act_idx[i] < m_act_cnt[i]) ? 1 : 0;
            e_out  = (active == 1) ? beat_of(i, m_act_data[i], m_act_idx[i]) : ((i == 0) ? 1 : 3);
            check($sformatf("m%0d.data_out", i), (i == 0) ? int'(do_a) : int'(do_b), e_out);
            check($sformatf("m%0d.busy", i), (i == 0) ? int'(busy_a) : int'(busy_b), active);
            check($sformatf("m%0d.ready", i), (i == 0) ? int'(rdy_a) : int'(rdy_b), 1 - m_pend_v[i]);
            check($sformatf("m%0d.done_sig", i), (i == 0) ? int'(done_a) : int'(done_b),
                  (active == 0 && m_pend_v[i] == 0) ? 1 : 0);
            check($sformatf("m%0d.word_done", i), (i == 0) ? int'(wd_a) : int'(wd_b), m_wd[i]);
        end
    endtask

    task automatic set_in(input logic s, input logic [7:0] d, input logic [3:0] c,
                          input logic w, input logic a);
        st = s; din = d; wc = c; ws = w; ab = a;
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check_model();
    endtask

    initial begin
        int pulses;
        logic [15:0] stream;
        int exp_seq[5];

        vecs[0]  = '{1'b1, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h9C, 4'd8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 8'h9C, 4'd8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h01, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 13; k <= 18; k++)
            vecs[k] = '{1'b0, 8'h01, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h01, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h01, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b0;
        set_in(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge sys_clk);
        check_model();
        rst = 1'b1;

        // 9C stream, zero-length word, and a clamped count of 15.
        for (int v = 0; v < 21; v++) begin
            set_in(vecs[v].st, vecs[v].d, vecs[v].wc, vecs[v].ws, vecs[v].ab);
            step();
            check($sformatf("vec%0d.data_out", v), int'(do_a), int'(vecs[v].e_out));
            check($sformatf("vec%0d.busy", v), int'(busy_a), int'(vecs[v].e_busy));
            check($sformatf("vec%0d.ready", v), int'(rdy_a), int'(vecs[v].e_ready));
            check($sformatf("vec%0d.done_sig", v), int'(done_a), int'(vecs[v].e_done));
            check($sformatf("vec%0d.word_done", v), int'(wd_a), int'(vecs[v].e_wd));
        end

        // Asynchronous reset in the middle of a word, then a fresh short word.
        set_in(1'b1, 8'hF0, 4'd6, 1'b0, 1'b0);
        step();
        check("rst_mid.beat0", int'(do_a), 1);
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 8'hF0, 4'd6, 1'b1, 1'b0);
            step();
        end
        set_in(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        check_model();
        check("rst_mid.data_out", int'(do_a), 1);
        check("rst_mid.busy", int'(busy_a), 0);
        check("rst_mid.done_sig", int'(done_a), 1);
        check("rst_mid.word_done", int'(wd_a), 0);
        #1;
        rst = 1'b1;
        exp_seq = '{0, 1, 0, 1, 1};
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_in(1'b1, 8'h50, 4'd4, 1'b0, 1'b0);
            else set_in(1'b0, 8'h50, 4'd4, 1'b1, 1'b0);
            step();
            check($sformatf("w50.beat%0d", k), int'(do_a), exp_seq[k]);
            check($sformatf("w50.word_done%0d", k), int'(wd_a), (k == 4) ? 1 : 0);
        end

        // Back-to-back A5 then 3C with a third start while the pending slot is full.
        stream = 16'hA53C;
        pulses = 0;
        for (int j = 0; j <= 16; j++) begin
            if (j == 0) set_in(1'b1, 8'hA5, 4'd8, 1'b0, 1'b0);
            else if (j == 2) set_in(1'b1, 8'h3C, 4'd8, 1'b1, 1'b0);
            else if (j == 3) set_in(1'b1, 8'hFF, 4'd8, 1'b1, 1'b0);
            else set_in(1'b0, 8'h00, 4'd8, 1'b1, 1'b0);
            step();
            pulses += int'(wd_a);
            if (j < 16) begin
                check($sformatf("b2b.bit%0d", j), int'(do_a), int'(stream[15-j]));
                check($sformatf("b2b.busy%0d", j), int'(busy_a), 1);
                check($sformatf("b2b.ready%0d", j), int'(rdy_a), (j >= 2 && j <= 7) ? 0 : 1);
            end
        end
        set_in(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        step();
        check("b2b.word_done_pulses", pulses, 2);
        check("b2b.end_busy", int'(busy_a), 0);
        check("b2b.end_done_sig", int'(done_a), 1);

        // Two lanes, LSB-first.
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_in(1'b1, 8'hE4, 4'd4, 1'b0, 1'b0);
            else set_in(1'b0, 8'hE4, 4'd4, 1'b1, 1'b0);
            step();
            check($sformatf("lane2.beat%0d", k), int'(do_b), (k < 4) ? k : 3);
            check($sformatf("lane2.word_done%0d", k), int'(wd_b), (k == 4) ? 1 : 0);
        end

        // Abort together with write_sig and start while a word is pending.
        set_in(1'b1, 8'hA5, 4'd8, 1'b0, 1'b0);
        step();
        set_in(1'b0, 8'hA5, 4'd8, 1'b1, 1'b0);
        step();
        set_in(1'b1, 8'h3C, 4'd8, 1'b0, 1'b0);
        step();
        check("abort.pending_held", int'(rdy_a), 0);
        set_in(1'b1, 8'h77, 4'd8, 1'b1, 1'b1);
        step();
        check("abort.busy", int'(busy_a), 0);
        check("abort.ready", int'(rdy_a), 1);
        check("abort.done_sig", int'(done_a), 1);
        check("abort.data_out", int'(do_a), 1);
        check("abort.word_done", int'(wd_a), 0);
        set_in(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
        step();
        check("abort.no_late_done", int'(wd_a), 0);
        check("abort.stays_idle", int'(busy_a), 0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                   8'($urandom_range(0, 255)),
                   ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_lane_write_buffer.md
Name: serial_lane_write_buffer

Overview:
- Parametrised successor to the single-bit serial write buffer.
- Accepts a parallel word and shifts it onto 1..LANES output lines, one beat per externally synchronised write strobe; MSB-first or LSB-first is selectable.
- Holds one pending word in a second slot, so back-to-back words are sent without a gap.
- Sits between protocol FSMs and the edge-detector-generated write_sig in the MITM datapath.

Parameters:
- BUF_SIZE, 8: word width in bits. Must be a multiple of LANES.
- LANES, 1: output lines driven per beat.
- MSB_FIRST, 1: 1 means the high-order beat goes first and data is left-aligned. 0 means the low-order beat goes first and data is right-aligned.
- IDLE_LEVEL, 1'b1: level driven on every data_out line when not shifting.
- Derived: BEATS = BUF_SIZE/LANES; CNT_W = $clog2(BEATS+1).

Ports:
- sys_clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to queue data_in/write_count; accepted when start && ready at a clock edge.
- data_in  in  BUF_SIZE  word to send.
- write_count  in  CNT_W  number of beats to send; values above BEATS are clamped to BEATS.
- write_sig  in  1  one-cycle synchronous strobe; advances one beat.
- abort  in  1  synchronous flush of active and pending words.
- data_out  out  LANES  serial lines.
- ready  out  1  pending slot free.
- busy  out  1  a word is being shifted.
- done_sig  out  1  level: high when idle with no pending word.
- word_done  out  1  one-cycle pulse per completed word.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out={LANES{IDLE_LEVEL}}, busy=0, done_sig=1, word_done=0, ready=1.
  - Pending slot and beat counter cleared.
- States are IDLE and SHIFT. ready = !pending_valid (registered). done_sig = (state==IDLE) && !pending_valid.
- Accepting a word in IDLE:
  - On an accepted start with count>0, data_out shows beat 0 on the next cycle; busy=1, state=SHIFT, remaining=count.
  - A write_sig in the accept cycle is ignored.
  - Accepted start with count==0: no state change; word_done pulses the next cycle.
- Beat selection:
  - MSB_FIRST=1: beat k = data_in[BUF_SIZE-1-k*LANES -: LANES].
  - MSB_FIRST=0: beat k = data_in[k*LANES +: LANES].
  - Within a beat, data_out[LANES-1] carries the higher-index bit.
- Shifting in SHIFT, on each write_sig: remaining decrements. If remaining>0 afterwards, the next beat appears the next cycle.
- On the write_sig that brings remaining to 0:
  - word_done=1 for exactly one cycle, the cycle after that write_sig.
  - If pending_valid: the pending word loads (beat 0 shown next cycle), pending clears, ready=1, and busy stays 1 with no idle gap.
  - Otherwise: state=IDLE, busy=0, data_out=IDLE_LEVEL, done_sig=1.
- Accepting a word in SHIFT: an accepted start stores into the pending slot and ready drops the next cycle. A start while ready=0 is ignored and the stored pending word is untouched.
- Simultaneous final write_sig and accepted start with pending empty: the new word loads directly as the active word.
- Simultaneous final write_sig and pending load with count==0: word_done pulses for the first word, then again the following cycle; the block goes IDLE.
- abort:
  - Takes priority over start and write_sig.
  - Next cycle: IDLE, pending cleared, data_out=IDLE_LEVEL, busy=0, ready=1, done_sig=1.
  - No word_done pulse is generated by an abort.
- Asynchronous reset mid-word behaves the same as abort, but takes effect immediately.
- Latency: start to first beat is 1 cycle; write_sig to next beat is 1 cycle.
- Beat data must be stable before the external rising edge, because write_sig is derived from the falling edge.

Test Plan:
- LANES=1, MSB_FIRST=1, data_in=8'h9C, count=8, then 8 write_sig strobes -> data_out sequence 1,0,0,1,1,1,0,0; one word_done pulse after the 8th strobe; data_out returns to 1 and done_sig=1.
- LANES=1, data_in=8'hF0 (6'o74<<2), count=6; rst pulsed low after 3 strobes -> outputs at reset values immediately, no word_done pulse; then data_in=8'h50, count=4 -> sequence 0,1,0,1, with word_done after the 4th strobe.
- Back-to-back: start 8'hA5 count 8, then start 8'h3C during the 2nd beat -> ready=0 until the first word completes; the 16-beat stream 10100101 00111100 has no idle cycle; two word_done pulses; a third start while ready=0 is ignored.
- LANES=2, MSB_FIRST=0, data_in=8'b11_10_01_00, count=4 -> data_out sequence 2'b00, 2'b01, 2'b10, 2'b11.
- abort asserted on the same cycle as write_sig and start with a pending word -> next cycle IDLE, pending dropped, data_out=IDLE_LEVEL, no word_done.
- Edge cases: count=0 -> immediate word_done and no beats; count=15 with BUF_SIZE=8 -> clamped to 8 beats.
